fifo245_rx: RTL and testbench

FIFO245_RX -- requirements
Module: fifo245_rx

---
 rtl/fifo245_pkg.sv | 17 +
 rtl/fifo245_rx_byte_fifo.sv | 62 ++++++
 rtl/fifo245_rx.sv | 131 +++++++++++++
 tb/tb_fifo245_rx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo245_pkg.sv
// fifo245_pkg
// Shared definitions for the FT245 synchronous-mode blocks (reader, writer,
// bus arbiter): the reader state encoding and the default buffer depth.
package fifo245_pkg;

    // Reader bus-cycle states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OE      = 2'd1,
        ST_READ    = 2'd2,
        ST_RELEASE = 2'd3
    } rx_state_e;

    // Default receive-buffer depth (power of two, >= 2).
    localparam int FIFO245_DEPTH = 4;

endpackage

// File: rtl/fifo245_rx_byte_fifo.sv
// byte_fifo
// Synchronous first-word-fall-through byte FIFO.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   push_i, data_i    write request and byte
//   pop_i             read request (ignored when empty)
//   data_o            head byte, 8'h00 while empty
//   count_o           number of stored bytes ($clog2(DEPTH)+1 bits)
//   full_o, empty_o   status flags
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A push while full is only tolerated when the same edge also frees a slot.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the empty gate below hides stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full_o));

endmodule

// File: rtl/fifo245_rx.sv
// fifo245_rx
// FT245 synchronous-mode receive path: owns the bus while granted, strobes
// bytes out of the FT245 into a small FWFT buffer and counts them.
// Ports:
//   clk, rst_n        FT245 CLKOUT, synchronous active-low reset
//   rxf_n, data_in    FT245 data-available flag and data bus (input only)
//   bus_gnt           arbiter grant; high = this reader may own the bus
//   oe_n, rd_n        registered FT245 output enable / read strobe
//   out_data/out_valid/out_ready  consumer stream; a byte moves on any edge
//                     where out_valid && out_ready (valid does not wait on ready)
//   busy              high whenever the reader is not IDLE
//   rx_count          bytes captured since reset, modulo 2^16
//   state_dbg         current reader state
module fifo245_rx
    import fifo245_pkg::*;
#(
    parameter int DEPTH = FIFO245_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rxf_n,
    input  logic [7:0]  data_in,
    input  logic        bus_gnt,
    output logic        oe_n,
    output logic        rd_n,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic [15:0] rx_count,
    output rx_state_e   state_dbg
);
    localparam int CW = $clog2(DEPTH) + 1;

    rx_state_e     state_q, state_d;
    logic          oe_n_q, oe_n_d;
    logic          rd_n_q, rd_n_d;
    logic [15:0]   rx_count_q;

    logic          push, pop;
    logic [CW-1:0] fifo_count, count_after;
    logic          fifo_full, fifo_empty;

    // The FT245 presents a byte on every edge the registered strobe is low
    // and it still has data; that is exactly when a byte is taken.
    assign push = !rd_n_q && !rxf_n;
    assign pop  = out_ready && !fifo_empty;

    // Occupancy as it will be after this edge; used to stop a burst before
    // the FT245 can hand over a byte with no room for it.
    assign count_after = fifo_count + CW'(push) - CW'(pop);

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (data_in),
        .pop_i   (pop),
        .data_o  (out_data),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // State register, registered pins and byte counter. Reset drops oe_n and
    // rd_n high on the same edge, skipping RELEASE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            oe_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            rx_count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            oe_n_q  <= oe_n_d;
            rd_n_q  <= rd_n_d;
            if (push) rx_count_q <= rx_count_q + 16'd1;
        end
    end

    // Next state. oe_n leads rd_n by one cycle on the way in and trails it
    // by one cycle on the way out.
    always_comb begin
        state_d = state_q;
        oe_n_d  = oe_n_q;
        rd_n_d  = rd_n_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_gnt && !rxf_n && !fifo_full) begin
                    state_d = ST_OE;
                    oe_n_d  = 1'b0;
                end
            end
            ST_OE: begin
                if (rxf_n || !bus_gnt) begin
                    state_d = ST_IDLE;
                    oe_n_d  = 1'b1;
                end else begin
                    state_d = ST_READ;
                    rd_n_d  = 1'b0;
                end
            end
            ST_READ: begin
                if (rxf_n || !bus_gnt || (count_after == CW'(DEPTH))) begin
                    state_d = ST_RELEASE;
                    rd_n_d  = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                oe_n_d  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                oe_n_d  = 1'b1;
                rd_n_d  = 1'b1;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        oe_n      = oe_n_q;
        rd_n      = rd_n_q;
        out_valid = !fifo_empty;
        busy      = (state_q != ST_IDLE);
        rx_count  = rx_count_q;
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_fifo245_rx.sv
module tb_fifo245_rx;
  import fifo245_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rxf_n;
  logic [7:0]  data_in;
  logic        bus_gnt;
  logic        oe_n;
  logic        rd_n;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [15:0] rx_count;
  rx_state_e   state_dbg;

  always #5 clk = ~clk;

  fifo245_rx #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxf_n     (rxf_n),
    .data_in   (data_in),
    .bus_gnt   (bus_gnt),
    .oe_n      (oe_n),
    .rd_n      (rd_n),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .rx_count  (rx_count),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int passes = 0;

  // FT245 host model: bytes waiting in the chip; one leaves per strobed edge.
  logic [7:0] host_q[$];
  // Bytes the consumer accepted, in order.
  logic [7:0] got_q[$];
  bit host_en = 1'b1;

  // ---------------- driver tasks ----------------
  // One clock: record consumer pops, advance the host model, sample #1 later.
  task automatic step();
    bit cap;
    cap = rst_n && (rd_n === 1'b0) && (rxf_n === 1'b0);
    if (rst_n && out_valid === 1'b1 && out_ready) got_q.push_back(out_data);
    @(posedge clk);
    #1;
    if (cap && host_en && host_q.size() > 0) void'(host_q.pop_front());
    if (host_en) begin
      rxf_n   = (host_q.size() == 0);
      data_in = (host_q.size() > 0) ? host_q[0] : 8'h00;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    host_q.delete();
    got_q.delete();
    host_en   = 1'b1;
    rxf_n     = 1'b1;
    data_in   = 8'h00;
    bus_gnt   = 1'b0;
    out_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (oe_n !== 1'b1) $display("FAIL rst_oe_n: got %b exp 1", oe_n); else passes++;
    checks++; if (rd_n !== 1'b1) $display("FAIL rst_rd_n: got %b exp 1", rd_n); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b exp 0", out_valid); else passes++;
    checks++; if (rx_count !== 16'h0000) $display("FAIL rst_rx_count: got %h exp 0000", rx_count); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else passes++;
    checks++; if (out_data !== 8'h00) $display("FAIL rst_out_data: got %h exp 00", out_data); else passes++;
    checks++; if (state_dbg !== ST_IDLE) $display("FAIL rst_state: got %0d exp %0d", state_dbg, ST_IDLE); else passes++;
  endtask

  task automatic test_basic_burst();
    do_reset();
    bus_gnt = 1'b1; out_ready = 1'b1;
    host_q = '{8'hA1, 8'hB2, 8'hC3};
    rxf_n = 1'b0; data_in = 8'hA1;
    step();
    checks++; if (oe_n !== 1'b0) $display("FAIL t1_oe_c1: got %b exp 0", oe_n); else passes++;
    checks++; if (rd_n !== 1'b1) $display("FAIL t1_rd_c1: got %b exp 1", rd_n); else passes++;
    step();
    checks++; if (rd_n !== 1'b0) $display("FAIL t1_rd_c2: got %b exp 0", rd_n); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL t1_valid_c2: got %b exp 0", out_valid); else passes++;
    step();
    checks++; if (out_valid !== 1'b1) $display("FAIL t1_latency_valid: got %b exp 1", out_valid); else passes++;
    checks++; if (out_data !== 8'hA1) $display("FAIL t1_latency_data: got %h exp a1", out_data); else passes++;
    step(); step(); step();
    checks++; if (state_dbg !== ST_RELEASE) $display("FAIL t1_release: got %0d exp %0d", state_dbg, ST_RELEASE); else passes++;
    checks++; if (rd_n !== 1'b1 || oe_n !== 1'b0) $display("FAIL t1_release_pins: got rd_n=%b oe_n=%b exp 1/0", rd_n, oe_n); else passes++;
    step();
    checks++; if (oe_n !== 1'b1 || busy !== 1'b0) $display("FAIL t1_idle: got oe_n=%b busy=%b exp 1/0", oe_n, busy); else passes++;
    checks++; if (rx_count !== 16'd3) $display("FAIL t1_rx_count: got %0d exp 3", rx_count); else passes++;
    checks++; if (got_q.size() != 3) $display("FAIL t1_nbytes: got %0d exp 3", got_q.size()); else passes++;
    checks++; if ({got_q[0], got_q[1], got_q[2]} !== 24'hA1B2C3)
      $display("FAIL t1_order: got %h%h%h exp a1b2c3", got_q[0], got_q[1], got_q[2]); else passes++;
  endtask

  task automatic test_full_backpressure();
    do_reset();
    for (int i = 0; i < 10; i++) host_q.push_back(8'h10 + 8'(i));
    rxf_n = 1'b0; data_in = 8'h10; bus_gnt = 1'b1; out_ready = 1'b0;
    repeat (5) step();
    checks++; if (rd_n !== 1'b0 || rx_count !== 16'd3) $display("FAIL t2_third: got rd_n=%b cnt=%0d exp 0/3", rd_n, rx_count); else passes++;
    step();
    checks++; if (rd_n !== 1'b1 || rx_count !== 16'd4) $display("FAIL t2_stop: got rd_n=%b cnt=%0d exp 1/4", rd_n, rx_count); else passes++;
    step();
    checks++; if (oe_n !== 1'b1) $display("FAIL t2_oe_release: got %b exp 1", oe_n); else passes++;
    repeat (5) step();
    checks++; if (oe_n !== 1'b1 || rd_n !== 1'b1) $display("FAIL t2_hold_idle: got oe_n=%b rd_n=%b exp 1/1", oe_n, rd_n); else passes++;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h10) $display("FAIL t2_head: got v=%b d=%h exp 1/10", out_valid, out_data); else passes++;
    checks++; if (rx_count !== 16'd4) $display("FAIL t2_no_overflow: got %0d exp 4", rx_count); else passes++;
    out_ready = 1'b1;
    step();
    checks++; if (oe_n !== 1'b1 || got_q.size() != 1) $display("FAIL t2_first_pop: got oe_n=%b pops=%0d exp 1/1", oe_n, got_q.size()); else passes++;
    step();
    checks++; if (oe_n !== 1'b0) $display("FAIL t2_restart: got %b exp 0", oe_n); else passes++;
    repeat (20) step();
    checks++; if (rx_count !== 16'd10) $display("FAIL t2_total: got %0d exp 10", rx_count); else passes++;
    checks++; if (got_q.size() != 10) $display("FAIL t2_nbytes: got %0d exp 10", got_q.size()); else passes++;
    for (int i = 0; i < 10; i++) begin
      checks++; if (got_q[i] !== 8'h10 + 8'(i)) $display("FAIL t2_byte%0d: got %h exp %h", i, got_q[i], 8'h10 + 8'(i)); else passes++;
    end
  endtask

  task automatic test_grant_drop();
    do_reset();
    for (int i = 0; i < 5; i++) host_q.push_back(8'h30 + 8'(i));
    rxf_n = 1'b0; data_in = 8'h30; bus_gnt = 1'b1; out_ready = 1'b1;
    repeat (3) step();
    bus_gnt = 1'b0;
    step();
    checks++; if (rd_n !== 1'b1 || oe_n !== 1'b0) $display("FAIL t3_rd_rise: got rd_n=%b oe_n=%b exp 1/0", rd_n, oe_n); else passes++;
    checks++; if (rx_count !== 16'd2) $display("FAIL t3_two_bytes: got %0d exp 2", rx_count); else passes++;
    step();
    checks++; if (oe_n !== 1'b1 || busy !== 1'b0) $display("FAIL t3_oe_rise: got oe_n=%b busy=%b exp 1/0", oe_n, busy); else passes++;
    repeat (2) step();
    checks++; if (oe_n !== 1'b1 || rx_count !== 16'd2) $display("FAIL t3_wait_gnt: got oe_n=%b cnt=%0d exp 1/2", oe_n, rx_count); else passes++;
    bus_gnt = 1'b1;
    step();
    checks++; if (oe_n !== 1'b0) $display("FAIL t3_regrant: got %b exp 0", oe_n); else passes++;
    repeat (12) step();
    checks++; if (rx_count !== 16'd5 || got_q.size() != 5) $display("FAIL t3_total: got cnt=%0d pops=%0d exp 5/5", rx_count, got_q.size()); else passes++;
    checks++; if (got_q[1] !== 8'h31 || got_q[4] !== 8'h34) $display("FAIL t3_order: got %h,%h exp 31,34", got_q[1], got_q[4]); else passes++;
  endtask

  task automatic test_rxf_glitch();
    bit rd_low;
    do_reset();
    host_en = 1'b0;
    bus_gnt = 1'b1; out_ready = 1'b1; rxf_n = 1'b0; data_in = 8'h55;
    step();
    rd_low = (rd_n === 1'b0);
    checks++; if (oe_n !== 1'b0) $display("FAIL t4_oe_fall: got %b exp 0", oe_n); else passes++;
    rxf_n = 1'b1;
    step();
    rd_low = rd_low || (rd_n === 1'b0);
    checks++; if (oe_n !== 1'b1 || state_dbg !== ST_IDLE) $display("FAIL t4_abort: got oe_n=%b st=%0d exp 1/0", oe_n, state_dbg); else passes++;
    for (int i = 0; i < 4; i++) begin
      step();
      rd_low = rd_low || (rd_n === 1'b0);
    end
    checks++; if (rd_low !== 1'b0) $display("FAIL t4_rd_never: got %b exp 0", rd_low); else passes++;
    checks++; if (rx_count !== 16'd0 || out_valid !== 1'b0) $display("FAIL t4_no_capture: got cnt=%0d v=%b exp 0/0", rx_count, out_valid); else passes++;
    host_en = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 6; i++) host_q.push_back(8'h50 + 8'(i));
    rxf_n = 1'b0; data_in = 8'h50; bus_gnt = 1'b1; out_ready = 1'b0;
    repeat (4) step();
    checks++; if (rx_count !== 16'd2 || rd_n !== 1'b0) $display("FAIL t5_setup: got cnt=%0d rd_n=%b exp 2/0", rx_count, rd_n); else passes++;
    rst_n = 1'b0;
    step();
    checks++; if (oe_n !== 1'b1 || rd_n !== 1'b1) $display("FAIL t5_pins: got oe_n=%b rd_n=%b exp 1/1", oe_n, rd_n); else passes++;
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) $display("FAIL t5_flush: got v=%b d=%h exp 0/00", out_valid, out_data); else passes++;
    checks++; if (rx_count !== 16'd0 || busy !== 1'b0) $display("FAIL t5_count: got cnt=%0d busy=%b exp 0/0", rx_count, busy); else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int nb, eb, budget, shown, rd_gap;
    bit cap;
    do_reset();
    host_en = 1'b0;
    bus_gnt = 1'b1; out_ready = 1'b1; rxf_n = 1'b0; data_in = 8'h00;
    nb = 0; eb = 0; budget = 70000; shown = 0; rd_gap = 0;
    while (nb < 65537 && budget > 0) begin
      cap = (rd_n === 1'b0) && (rxf_n === 1'b0);
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== eb[7:0]) begin
          if (shown < 5) $display("FAIL t6_stream_byte%0d: got %h exp %h", eb, out_data, eb[7:0]);
          shown++;
        end else passes++;
        eb++;
      end
      @(posedge clk);
      #1;
      budget--;
      if (cap) begin
        nb++;
        if (nb == 65535) begin
          checks++; if (rx_count !== 16'hFFFF) $display("FAIL t6_preload: got %h exp ffff", rx_count); else passes++;
        end
      end
      if (nb >= 1 && nb < 65537 && rd_n !== 1'b0) rd_gap++;
      data_in = nb[7:0];
      rxf_n   = (nb >= 65537);
    end
    checks++; if (budget <= 0) $display("FAIL t6_timeout: got %0d captures exp 65537", nb); else passes++;
    checks++; if (rx_count !== 16'h0001) $display("FAIL t6_wrap: got %h exp 0001", rx_count); else passes++;
    checks++; if (rd_gap != 0) $display("FAIL t6_full_rate: got %0d stalls exp 0", rd_gap); else passes++;
    for (int i = 0; i < 6; i++) begin
      if (out_valid === 1'b1) begin
        checks++;
        if (out_data !== eb[7:0]) $display("FAIL t6_drain_byte%0d: got %h exp %h", eb, out_data, eb[7:0]); else passes++;
        eb++;
      end
      @(posedge clk);
      #1;
    end
    checks++; if (eb != 65537) $display("FAIL t6_no_loss: got %0d bytes exp 65537", eb); else passes++;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL t6_idle: got v=%b busy=%b exp 0/0", out_valid, busy); else passes++;
    host_en = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_burst();
    test_full_backpressure();
    test_grant_drop();
    test_rxf_glitch();
    test_reset_mid_burst();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
